// File: rtl/ofdm_fft_frame_feeder_if.sv
// Sample-stream bundle for the OFDM FFT frame feeder: synchroniser-side input
// stream, FFT sink-side valid/ready stream and the sticky status flags.
interface ofdm_fft_frame_feeder_if #(
  parameter int unsigned DATA_W = 18
);
  logic              in_valid;
  logic              in_sym_start;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;

  logic              fft_valid;
  logic              fft_ready;
  logic              fft_sop;
  logic              fft_eop;
  logic [DATA_W-1:0] fft_real;
  logic [DATA_W-1:0] fft_imag;
  logic [1:0]        fft_error;
  logic              fft_inverse;

  logic              ovf_err;
  logic              sync_err;

  // Driver of the input stream and consumer of the FFT stream.
  modport master (
    output in_valid, in_sym_start, in_real, in_imag, fft_ready,
    input  fft_valid, fft_sop, fft_eop, fft_real, fft_imag,
           fft_error, fft_inverse, ovf_err, sync_err
  );

  // The framer itself.
  modport slave (
    input  in_valid, in_sym_start, in_real, in_imag, fft_ready,
    output fft_valid, fft_sop, fft_eop, fft_real, fft_imag,
           fft_error, fft_inverse, ovf_err, sync_err
  );
endinterface

// File: rtl/ofdm_fft_frame_feeder.sv
// Receive-side OFDM framer: strips the cyclic prefix from the continuous
// synchroniser stream, tags FFT_LEN samples as one sop/eop frame and buffers
// them in a first-word-fall-through FIFO toward the FFT sink port.
module ofdm_fft_frame_feeder #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned FFT_LEN    = 64,
  parameter int unsigned CP_LEN     = 16,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  ofdm_fft_frame_feeder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FFT_LEN);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = 2 * DATA_W + 2;

  localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP_CP,
    COLLECT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync_err_q;
  logic             ovf_err_q;

  logic             push;
  logic             push_sop;
  logic             push_eop;
  logic [ENT_W-1:0] push_word;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [ENT_W-1:0] hold_q;

  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] out_word;

  // Decode which valid input samples become frame samples. This is combinational
  // so a sample lands in the FIFO on the same edge it is presented.
  always_comb begin
    push     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        IDLE:    push = bus.in_sym_start && (CP_LEN == 0);
        COLLECT: push = 1'b1;
        default: push = 1'b0;
      endcase
    end
    push_sop = (state_q == IDLE) || (cnt_q == '0);
    push_eop = (state_q == COLLECT) && (cnt_q == FRM_LAST);
  end

  assign push_word = {push_sop, push_eop, bus.in_real, bus.in_imag};

  // Framing FSM: IDLE waits for a symbol start, SKIP_CP discards the prefix,
  // COLLECT counts out exactly FFT_LEN samples then returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.in_sym_start) begin
            if (CP_LEN == 0) begin
              // start sample is already frame sample 0
              state_q <= COLLECT;
              cnt_q   <= CNT_W'(1);
            end else if (CP_LEN == 1) begin
              state_q <= COLLECT;
              cnt_q   <= '0;
            end else begin
              state_q <= SKIP_CP;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        SKIP_CP: begin
          if (bus.in_sym_start) begin
            cnt_q <= CNT_W'(1);
          end else if (cnt_q == CP_LAST) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COLLECT: begin
          if (bus.in_sym_start) begin
            sync_err_q <= 1'b1;
          end
          if (cnt_q == FRM_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = !empty && bus.fft_ready;
  assign wr_en = push && (!full || pop);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
    end
  end

  // FIFO pointers, overflow flag and the held copy of the last delivered entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_err_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= head;
      end
      if (push && full && !pop) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

  // When empty the outputs keep showing the last entry handed to the FFT.
  assign out_word = empty ? hold_q : head;

  assign bus.fft_valid   = !empty;
  assign bus.fft_sop     = out_word[ENT_W-1];
  assign bus.fft_eop     = out_word[ENT_W-2];
  assign bus.fft_real    = out_word[2*DATA_W-1:DATA_W];
  assign bus.fft_imag    = out_word[DATA_W-1:0];
  assign bus.fft_error   = 2'b00;
  assign bus.fft_inverse = 1'b0;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_ofdm_fft_frame_feeder.sv
// Self-checking bench for ofdm_fft_frame_feeder: directed framing scenarios
// plus randomized traffic, compared each cycle against a symbol-position model.
module tb_ofdm_fft_frame_feeder;

  localparam int DATA_W     = 18;
  localparam int FFT_LEN    = 64;
  localparam int CP_LEN     = 16;
  localparam int FIFO_DEPTH = 128;
  localparam int ENT_W      = 2 * DATA_W + 2;
  localparam int SYM_LEN    = CP_LEN + FFT_LEN;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ofdm_fft_frame_feeder_if #(.DATA_W(DATA_W)) bus_if ();

  ofdm_fft_frame_feeder #(
    .DATA_W    (DATA_W),
    .FFT_LEN   (FFT_LEN),
    .CP_LEN    (CP_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model: position inside the current symbol (-1 = no symbol)
  int               pos;
  bit               m_ovf;
  bit               m_sync;
  logic [ENT_W-1:0] mq[$];
  logic [ENT_W-1:0] m_last;

  // entries the DUT actually handed over (valid && ready)
  logic [ENT_W-1:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pos    = -1;
    m_ovf  = 1'b0;
    m_sync = 1'b0;
    mq.delete();
    m_last = '0;
  endtask

  task automatic compare_outputs();
    logic [63:0] exp_v;
    logic [63:0] got_v;
    exp_v = {23'd0, (mq.size() != 0), ((mq.size() != 0) ? mq[0] : m_last), m_ovf, m_sync};
    got_v = {23'd0, bus_if.fft_valid, bus_if.fft_sop, bus_if.fft_eop,
             bus_if.fft_real, bus_if.fft_imag, bus_if.ovf_err, bus_if.sync_err};
    chk("out", got_v, exp_v);
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit v, input bit ss, input logic [DATA_W-1:0] re,
                      input logic [DATA_W-1:0] im, input bit rdy);
    logic [ENT_W-1:0] w;
    bit               have_push;
    bit               do_pop;
    bus_if.in_valid     = v;
    bus_if.in_sym_start = ss;
    bus_if.in_real      = re;
    bus_if.in_imag      = im;
    bus_if.fft_ready    = rdy;
    if (bus_if.fft_valid && rdy)
      got_q.push_back({bus_if.fft_sop, bus_if.fft_eop, bus_if.fft_real, bus_if.fft_imag});

    do_pop    = (mq.size() != 0) && rdy;
    have_push = 1'b0;
    w         = '0;
    if (v) begin
      if (ss && pos >= CP_LEN) m_sync = 1'b1;
      else if (ss)             pos = 0;
      if (pos >= 0) begin
        if (pos >= CP_LEN) begin
          w = {(pos == CP_LEN), (pos == SYM_LEN - 1), re, im};
          have_push = 1'b1;
        end
        if (pos == SYM_LEN - 1) pos = -1;
        else                    pos++;
      end
    end
    if (do_pop) m_last = mq.pop_front();
    if (have_push) begin
      if (mq.size() >= FIFO_DEPTH) m_ovf = 1'b1;
      else                         mq.push_back(w);
    end

    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    bus_if.in_valid     = 1'b0;
    bus_if.in_sym_start = 1'b0;
    bus_if.fft_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DATA_W'($urandom), DATA_W'($urandom), rdy);
  endtask

  // Delivered frames must carry input indices sym*SYM_LEN+CP_LEN+k with sop/eop framing.
  task automatic check_seq(input string tag, input int n_exp);
    logic [63:0] exp_v;
    logic [63:0] got_v;
    int          sym;
    int          k;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
      sym   = i / FFT_LEN;
      k     = i % FFT_LEN;
      exp_v = {44'd0, (k == 0), (k == FFT_LEN - 1), DATA_W'(sym * SYM_LEN + CP_LEN + k)};
      got_v = {44'd0, got_q[i][ENT_W-1], got_q[i][ENT_W-2], got_q[i][2*DATA_W-1:DATA_W]};
      chk(tag, got_v, exp_v);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.in_real = '0;
    bus_if.in_imag = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("consts", {62'd0, bus_if.fft_error, bus_if.fft_inverse}, 64'd0);

    // single symbol, continuous input, ready always high
    got_q.delete();
    for (int i = 0; i < SYM_LEN; i++)
      step(1'b1, i == 0, DATA_W'(i), DATA_W'($urandom), 1'b1);
    idle(10, 1'b1);
    check_seq("single", FFT_LEN);

    // two back-to-back symbols, ready toggling every cycle
    do_reset();
    got_q.delete();
    for (int i = 0; i < 2 * SYM_LEN; i++)
      step(1'b1, (i % SYM_LEN) == 0, DATA_W'(i), DATA_W'($urandom), (i % 2) == 0);
    idle(100, 1'b1);
    check_seq("b2b", 2 * FFT_LEN);

    // ready held low across three symbols: FIFO fills, remainder dropped
    do_reset();
    got_q.delete();
    for (int i = 0; i < 3 * SYM_LEN; i++)
      step(1'b1, (i % SYM_LEN) == 0, DATA_W'(i), DATA_W'($urandom), 1'b0);
    chk("ovf_flag", 64'(bus_if.ovf_err), 64'd1);
    idle(FIFO_DEPTH + 10, 1'b1);
    check_seq("ovf", FIFO_DEPTH);

    // stray symbol start inside COLLECT, then a clean symbol
    do_reset();
    got_q.delete();
    for (int i = 0; i < 2 * SYM_LEN; i++)
      step(1'b1, (i % SYM_LEN) == 0 || i == CP_LEN + 30, DATA_W'(i), DATA_W'($urandom), 1'b1);
    idle(10, 1'b1);
    chk("sync_flag", 64'(bus_if.sync_err), 64'd1);
    check_seq("sync", 2 * FFT_LEN);

    // gapped input: one valid sample every third cycle
    do_reset();
    got_q.delete();
    for (int i = 0; i < SYM_LEN; i++) begin
      step(1'b1, i == 0, DATA_W'(i), DATA_W'($urandom), 1'b1);
      step(1'b0, 1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
      step(1'b0, 1'b0, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
    end
    idle(10, 1'b1);
    check_seq("gapped", FFT_LEN);

    // reset mid-COLLECT with data buffered, then a clean frame
    do_reset();
    for (int i = 0; i < CP_LEN + 30; i++)
      step(1'b1, i == 0, DATA_W'(i), DATA_W'($urandom), 1'b0);
    chk("pre_rst_valid", 64'(bus_if.fft_valid), 64'd1);
    do_reset();
    chk("post_rst_valid", 64'(bus_if.fft_valid), 64'd0);
    got_q.delete();
    for (int i = 0; i < SYM_LEN; i++)
      step(1'b1, i == 0, DATA_W'(i), DATA_W'($urandom), 1'b1);
    idle(10, 1'b1);
    check_seq("after_rst", FFT_LEN);

    // random traffic, mostly-ready sink then a starved sink
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      step(v, v && ($urandom_range(0, 59) == 0), DATA_W'($urandom), DATA_W'($urandom),
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = ($urandom_range(0, 1) != 0);
      step(v, v && ($urandom_range(0, 39) == 0), DATA_W'($urandom), DATA_W'($urandom),
           $urandom_range(0, 9) == 0);
    end
    idle(FIFO_DEPTH + 10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
